// File: rtl/sat_pkg.sv
// sat_pkg: mode encoding and saturating add helpers shared by the accumulate/clamp pipeline
package sat_pkg;
    typedef logic [1:0] satMode_t;
    localparam satMode_t SAT_SRANGE    = 2'd0;
    localparam satMode_t SAT_SPOSITIVE = 2'd1;
    localparam satMode_t SAT_UPOSITIVE = 2'd2;

    function automatic logic [63:0] satAddS(input logic [63:0] a, input logic [63:0] b, input int w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        s = signed'(a + b);
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        return s > hi ? hi : s < -hi - 64'sd1 ? -hi - 64'sd1 : s;
    endfunction

    function automatic logic satOvfS(input logic [63:0] a, input logic [63:0] b, input int w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        s = signed'(a + b);
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        return s > hi || s < -hi - 64'sd1;
    endfunction

    function automatic logic [63:0] satAddU(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [63:0] s;
        logic [63:0] hi;
        s = a + b;
        hi = (64'd1 << w) - 64'd1;
        return s > hi ? hi : s;
    endfunction

    function automatic logic satOvfU(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [63:0] s;
        logic [63:0] hi;
        s = a + b;
        hi = (64'd1 << w) - 64'd1;
        return s > hi;
    endfunction
endpackage

// File: rtl/sat_accum_clamp_if.sv
// sat_accum_clamp_if: valid/ready input and output streams of the accumulate/clamp block
interface sat_accum_clamp_if #(
    parameter int INW  = 16,
    parameter int OUTW = 8,
    parameter int CH   = 4
);
    import sat_pkg::*;
    logic                i_valid;
    logic                o_ready;
    satMode_t            i_mode;
    logic                i_accumulate;
    logic [CH*INW-1:0]   i_data;
    logic                o_valid;
    logic                i_ready;
    logic [CH*OUTW-1:0]  o_data;
    modport master(output i_valid, i_mode, i_accumulate, i_data, i_ready, input o_ready, o_valid, o_data);
    modport slave(input i_valid, i_mode, i_accumulate, i_data, i_ready, output o_ready, o_valid, o_data);
endinterface

// File: rtl/sat_clamp_lane.sv
// sat_clamp_lane: narrows one lane to OUTW bits with a signed-range, signed-positive or unsigned-positive clamp
module sat_clamp_lane import sat_pkg::*; #(
    parameter int INW  = 24,
    parameter int OUTW = 8
) (
    input  logic [INW-1:0]  value,
    input  satMode_t        mode,
    output logic [OUTW-1:0] clamped,
    output logic            sat
);
    localparam logic [INW-1:0] SHI = {{(INW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
    localparam logic [INW-1:0] SLO = {{(INW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};
    localparam logic [INW-1:0] PHI = {{(INW-OUTW){1'b0}}, {OUTW{1'b1}}};
    logic uns, pos, over, under;
    logic [INW-1:0] hi, lo;
    // Pick the bounds for the mode; the reserved mode falls back to the signed range
    always_comb begin
        uns = mode == SAT_UPOSITIVE;
        pos = mode == SAT_SPOSITIVE;
        hi = (uns | pos) ? PHI : SHI;
        lo = pos ? '0 : SLO;
        over = uns ? (value > PHI) : ($signed(value) > $signed(hi));
        under = !uns & ($signed(value) < $signed(lo));
        clamped = OUTW'(over ? hi : under ? lo : value);
        sat = over | under;
    end
endmodule

// File: rtl/sat_accum_clamp.sv
// sat_accum_clamp: per-lane saturating accumulator feeding a mode-selectable clamp, two-stage valid/ready pipeline
module sat_accum_clamp import sat_pkg::*; #(
    parameter int INW  = 16,
    parameter int OUTW = 8,
    parameter int ACCW = 24,
    parameter int CH   = 4
) (
    input  logic                 clk,
    input  logic                 nRst,
    input  logic                 i_clear,
    input  logic                 i_clearFlags,
    sat_accum_clamp_if.slave     bus,
    output logic [CH-1:0]        o_satFlags,
    output logic [15:0]          o_satCount
);
    logic s1Valid, s1Adv, s2Adv, accept, hs, load2, anySat;
    satMode_t s1Mode;
    logic [CH-1:0] laneSat, s2Sat;
    logic [CH*OUTW-1:0] laneOut;

    assign s2Adv = !bus.o_valid | bus.i_ready;
    assign s1Adv = !s1Valid | s2Adv;
    assign bus.o_ready = s1Adv & !i_clear;
    assign accept = bus.i_valid & bus.o_ready;
    assign hs = bus.o_valid & bus.i_ready;
    assign load2 = s2Adv & s1Valid & !i_clear;
    assign anySat = |s2Sat;

    for (genvar k = 0; k < CH; k++) begin : gLane
        logic [ACCW-1:0] acc, accNext;
        logic accSat, accSatNext, uns, clampSat;
        logic [INW-1:0] d;
        logic [63:0] ea, ed;
        assign d = bus.i_data[k*INW +: INW];
        // Extend operands by the incoming beat's mode, then load or saturating-add
        always_comb begin
            uns = bus.i_mode == SAT_UPOSITIVE;
            ea = uns ? 64'(acc) : 64'(signed'(acc));
            ed = uns ? 64'(d) : 64'(signed'(d));
            accNext = !bus.i_accumulate ? ACCW'(ed) : ACCW'(uns ? satAddU(ea, ed, ACCW) : satAddS(ea, ed, ACCW));
            accSatNext = bus.i_accumulate & (uns ? satOvfU(ea, ed, ACCW) : satOvfS(ea, ed, ACCW));
        end
        // The accumulator doubles as the stage-1 data register; it only moves on an accepted beat
        always_ff @(posedge clk or negedge nRst)
            if (!nRst) begin
                acc <= '0;
                accSat <= 1'b0;
            end else begin
                acc <= i_clear ? '0 : accept ? accNext : acc;
                accSat <= i_clear ? 1'b0 : accept ? accSatNext : accSat;
            end
        sat_clamp_lane #(.INW(ACCW), .OUTW(OUTW)) uClamp (
            .value(acc),
            .mode(s1Mode),
            .clamped(laneOut[k*OUTW +: OUTW]),
            .sat(clampSat)
        );
        assign laneSat[k] = clampSat | accSat;
    end

    // Stage-1 valid and the mode that travels with the beat
    always_ff @(posedge clk or negedge nRst)
        if (!nRst) begin
            s1Valid <= 1'b0;
            s1Mode <= SAT_SRANGE;
        end else begin
            s1Valid <= accept | (s1Valid & !s1Adv & !i_clear);
            s1Mode <= accept ? bus.i_mode : s1Mode;
        end

    // Stage-2 output register; holds while the consumer stalls
    always_ff @(posedge clk or negedge nRst)
        if (!nRst) begin
            bus.o_valid <= 1'b0;
            bus.o_data <= '0;
            s2Sat <= '0;
        end else begin
            bus.o_valid <= !i_clear & (s2Adv ? s1Valid : bus.o_valid);
            bus.o_data <= load2 ? laneOut : bus.o_data;
            s2Sat <= load2 ? laneSat : s2Sat;
        end

    // Sticky flags and event counter; a handshake beats a coincident flag clear
    always_ff @(posedge clk or negedge nRst)
        if (!nRst) begin
            o_satFlags <= '0;
            o_satCount <= '0;
        end else begin
            o_satFlags <= (i_clearFlags ? '0 : o_satFlags) | (hs ? s2Sat : '0);
            o_satCount <= i_clearFlags ? 16'(hs & anySat) : (hs & anySat & ~&o_satCount) ? o_satCount + 16'd1 : o_satCount;
        end
endmodule

// File: doc/sat_accum_clamp.md
Name: sat_accum_clamp

Overview:
- Multi-channel saturating accumulator followed by a run-time selectable output clamp.
- Next generation of the library's combinational clamp set (signed-range, signed-to-positive, unsigned-positive), folded into one parametrised, pipelined block.
- Adds a valid/ready stream interface, per-channel accumulation, sticky saturation flags and a saturation event counter.
- Used in front of narrow datapaths such as colour/blend and audio mix, where wide sums must be narrowed safely.

Parameters:
- INW, 16, input sample width per channel.
- OUTW, 8, output width per channel; OUTW < INW required.
- ACCW, 24, accumulator width per channel; ACCW >= INW required.
- CH, 4, number of channels (lanes), >= 1.

Ports:
- clk  in  1  single clock.
- nRst  in  1  asynchronous active-low reset.
- i_clear  in  1  sync clear: zero accumulators, flush pipeline.
- i_clearFlags  in  1  sync clear of sticky flags and counter.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept an input beat.
- i_mode  in  2  0=SRANGE, 1=SPOSITIVE, 2=UPOSITIVE, 3=reserved (behaves as 0).
- i_accumulate  in  1  1: acc += data; 0: acc = data (load).
- i_data  in  CH*INW  lane k at bits [k*INW +: INW].
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts an output beat.
- o_data  out  CH*OUTW  clamped results, same lane packing.
- o_satFlags  out  CH  sticky per-lane saturation.
- o_satCount  out  16  count of output beats with any lane saturated.

Behaviour:
- Reset (nRst low, asynchronous): accumulators, both stage valids, o_data, o_satFlags and o_satCount go to 0. After reset, o_ready=1.
- Accept = i_valid & o_ready. Output handshake = o_valid & i_ready.
- Pipeline has two register stages; latency is 2 cycles from accept to o_valid at full throughput. Sustains 1 beat/cycle.
- Stage 2 advances when !o_valid | i_ready.
- Stage 1 advances when !s1Valid | stage 2 advances.
- o_ready = (stage 1 advances) & !i_clear. It is combinational and has no dependency on i_valid.
- Stage 1 accumulation, per lane, using the mode of that beat:
  - Signed modes (0/1/3): data is sign-extended and accumulated with signed saturation to [-2^(ACCW-1), 2^(ACCW-1)-1].
  - Mode 2: data is zero-extended and accumulated with unsigned saturation to [0, 2^ACCW-1].
  - Load (i_accumulate=0) uses the same extension and never saturates.
  - The accumulator and stage-1 register hold the new value. The lane's accSat bit is carried forward with it.
- Stage 2 clamp, per lane, with the mode carried along the pipeline:
  - SRANGE clamps to [-2^(OUTW-1), 2^(OUTW-1)-1].
  - SPOSITIVE clamps a signed value to [0, 2^OUTW-1].
  - UPOSITIVE clamps an unsigned value to [0, 2^OUTW-1].
  - lane sat = clamp active | accSat.
- Mode change while accumulating: the accumulator bit pattern is reinterpreted under the new mode. This is defined behaviour, not an error; software loads first.
- Output holds stable: o_data and o_valid do not change while o_valid & !i_ready.
- Sticky flags and counter:
  - On each output handshake, o_satFlags |= lane sat vector.
  - If any lane saturated, o_satCount increments, saturating at 0xFFFF (no wrap).
  - i_clearFlags zeroes flags and counter. A handshake in the same cycle wins: flags = that beat's sat vector, count = 1 or 0.
- i_clear takes priority over everything except nRst:
  - Zeroes accumulators and both valids, so o_valid=0 next cycle and in-flight beats are discarded.
  - Forces o_ready=0 that cycle, so no beat is accepted.
  - Flags and counter are untouched.

Decomposition:
- Package sat_pkg holds:
  - mode constants SAT_SRANGE/SAT_SPOSITIVE/SAT_UPOSITIVE;
  - the mode typedef (2 bits);
  - functions for saturating signed and unsigned add at a given width.
- One sub-module: sat_clamp_lane (combinational; INW=ACCW, OUTW, mode in, value out, sat out). It is instantiated CH times in stage 2 and is the generalised replacement of the three fixed clamps.

Test Plan (INW=16, OUTW=8, ACCW=24, CH=4):
- Mode 0 load of lanes {300, -300, 100, -128} -> 2 cycles later o_data {127, -128, 100, -128}, o_satFlags=0b0011, o_satCount=1.
- Mode 1 load of {-5, 255, 256, 0} -> {0, 255, 255, 0}, flags 0b0101. Then mode 2 load 200 then accumulate 200 on lane 0 -> outputs 200, then 255 with flag set.
- Mode 0 on lane 0: load -32768, then accumulate -32768 255 times -> acc reaches -8388608 with no accSat. The next accumulate holds -8388608 and sets accSat.
- Continuous i_valid with i_ready held low 5 cycles -> o_ready drops once 2 beats are held, o_data stays stable. On release, all beats come out in order with none lost or duplicated.
- i_clear asserted with i_valid=1 and 2 beats in flight -> o_ready=0 that cycle, o_valid=0 next cycle, the next load reads from acc=0, flags and counter unchanged.
- nRst pulsed low mid-stream (asynchronous, not clock-aligned) -> all outputs zero immediately, o_ready=1 after release. i_clearFlags coincident with a saturating handshake -> count=1.
